// File: rtl/mult_sched_pkg.sv
// ============================================================================
// Module  : mult_sched_pkg
// Brief   : Shared types and constants for the multiplier scheduler.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_sched_pkg;

    localparam int NB_DEFAULT    = 16;
    localparam int NREQ_DEFAULT  = 4;
    localparam int TIMEOUT_SLACK = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_sched_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin one-hot grant with a rotating priority pointer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter  int NREQ = NREQ_DEFAULT,
    localparam int c_IW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_req,
    input  logic              i_advance,
    output logic [NREQ-1:0]   o_grant,
    output logic [c_IW-1:0]   o_grant_id
);

    logic [c_IW-1:0] r_ptr;
    logic            w_found;
    int              w_idx;

    // Scan from the pointer position, wrapping, and take the first request.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = c_IW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_id == c_IW'(NREQ - 1)) ? '0 : o_grant_id + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_sched.sv
// ============================================================================
// Module  : mult_sched
// Brief   : Schedules NREQ requesters onto one shared signed multiplier.
//           Optional macro MULT_SCHED_TIMEOUT_EN bounds the wait states.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_sched
    import mult_sched_pkg::*;
#(
    parameter  int NB   = NB_DEFAULT,
    parameter  int NREQ = NREQ_DEFAULT,
    localparam int c_IW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*NB-1:0]   req_a,
    input  logic [NREQ*NB-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [2*NB-1:0]      rsp_product,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [NB-1:0]        mul_a,
    output logic [NB-1:0]        mul_b,
    input  logic [2*NB-1:0]      mul_product,
    input  logic                 mul_ready
);

    state_t          r_state;
    state_t          w_next;
    logic [c_IW-1:0] r_owner;
    logic [NREQ-1:0] w_grant;
    logic [c_IW-1:0] w_gid;
    logic            w_accept;
    logic            w_capture;
    logic            w_to_take;
    logic            w_timeout;

    rr_arbiter #(
        .NREQ       (NREQ)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req_valid),
        .i_advance  (w_accept),
        .o_grant    (w_grant),
        .o_grant_id (w_gid)
    );

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int c_TO_LIMIT = NB + TIMEOUT_SLACK;
    localparam int c_TW       = $clog2(c_TO_LIMIT + 1);

    logic [c_TW-1:0] r_to_cnt;
    logic            r_err;

    // Counter is zero on the first WAIT_LO cycle and counts wait cycles.
    always_ff @(posedge clk) begin
        if (rst || r_state == ISSUE) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_LO || r_state == WAIT_HI) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == WAIT_LO || r_state == WAIT_HI) &&
                       (r_to_cnt == c_TW'(c_TO_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_err <= 1'b0;
        end else if (w_to_take) begin
            r_err <= 1'b1;
        end
    end

    assign rsp_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Outputs are gated by rst so reset values show while rst is held.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_to_take = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    req_ready = w_grant;
                    if (|w_grant) begin
                        w_accept = 1'b1;
                        w_next   = ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start = 1'b1;
                    w_next    = WAIT_LO;
                end
                // Waiting for ready low first ignores a stale ready level.
                WAIT_LO: begin
                    if (w_timeout) begin
                        w_to_take = 1'b1;
                        w_next    = RESP;
                    end else if (!mul_ready) begin
                        w_next = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (mul_ready) begin
                        w_capture = 1'b1;
                        w_next    = RESP;
                    end else if (w_timeout) begin
                        w_to_take = 1'b1;
                        w_next    = RESP;
                    end
                end
                RESP: begin
                    rsp_valid[r_owner] = 1'b1;
                    w_next             = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_product <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_gid;
                mul_a   <= req_a[w_gid*NB +: NB];
                mul_b   <= req_b[w_gid*NB +: NB];
            end
            if (w_capture) begin
                rsp_product <= mul_product;
            end else if (w_to_take) begin
                rsp_product <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_sched.sv
// ============================================================================
// Module  : tb_mult_sched
// Brief   : Self-checking bench for mult_sched with a behavioural multiplier.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_sched;

    localparam int NB     = 16;
    localparam int NREQ   = 4;
    localparam int LAT    = 3;
    localparam int MAXOPS = 128;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NB-1:0]   req_a = '0;
    logic [NREQ*NB-1:0]   req_b = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [2*NB-1:0]      rsp_product;
    logic                 rsp_err;
    logic                 mul_start;
    logic [NB-1:0]        mul_a;
    logic [NB-1:0]        mul_b;
    logic [2*NB-1:0]      mul_product;
    logic                 mul_ready;

    always #5 clk = ~clk;

    mult_sched #(
        .NB          (NB),
        .NREQ        (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_ready   (mul_ready)
    );

    // Shared multiplier: ready drops after start, rises LAT busy cycles later.
    logic [2*NB-1:0] m_prod  = '0;
    logic            m_ready = 1'b1;
    int              m_cnt   = 0;
    bit              m_stall = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            m_cnt   <= LAT;
            m_ready <= 1'b0;
            m_prod  <= $signed(mul_a) * $signed(mul_b);
        end else if (m_cnt > 0 && !m_stall) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_ready <= 1'b1;
        end
    end

    assign mul_product = m_prod;
    assign mul_ready   = m_ready;

    typedef struct {
        int          owner;
        logic [31:0] prod;
        bit          err;
        int          at;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          next_idle = 0;
    int          ptr     = 0;
    bit          in_reset = 1'b0;
    int          reset_cycles = 0;
    bit          stall_mode = 1'b0;
    int          acc_id = -1;
    int          exp_start_cyc = -1;
    logic [15:0] exp_ma, exp_mb;
    exp_t        expq[$];
    logic [15:0] op_a [NREQ][MAXOPS];
    logic [15:0] op_b [NREQ][MAXOPS];
    int          head [NREQ];
    int          tail [NREQ];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint pa, pb, p;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        return p[31:0];
    endfunction

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_a[i*NB +: NB]  = op_a[i][head[i]];
                req_b[i*NB +: NB]  = op_b[i][head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_a[i*NB +: NB]  = 16'($urandom);
                req_b[i*NB +: NB]  = 16'($urandom);
            end
        end
    endtask

    task automatic push(input int i, input logic [15:0] a, input logic [15:0] b);
        if (tail[i] < MAXOPS) begin
            op_a[i][tail[i]] = a;
            op_b[i][tail[i]] = b;
            tail[i]++;
        end
        refresh();
    endtask

    task automatic monitor();
        logic [63:0] exp_v;
        int          w;
        exp_t        e;
        cyc++;
        acc_id = -1;
        if (in_reset) begin
            if (reset_cycles > 0) begin
                check("rst_req_ready", req_ready, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_product", rsp_product, 0);
                check("rst_rsp_err", rsp_err, 0);
                check("rst_mul_start", mul_start, 0);
                check("rst_mul_a", mul_a, 0);
                check("rst_mul_b", mul_b, 0);
            end
            reset_cycles++;
            return;
        end
        check("mul_start", mul_start, (cyc == exp_start_cyc) ? 1 : 0);
        if (cyc == exp_start_cyc) begin
            check("mul_a", mul_a, exp_ma);
            check("mul_b", mul_b, exp_mb);
        end
        exp_v = 0;
        if (expq.size() > 0 && expq[0].at == cyc) exp_v = 64'(1) << expq[0].owner;
        check("rsp_valid", rsp_valid, exp_v);
        if (exp_v != 0) begin
            check("rsp_product", rsp_product, expq[0].prod);
            check("rsp_err", rsp_err, expq[0].err);
            void'(expq.pop_front());
        end
        if (|req_valid) begin
            if (cyc >= next_idle) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int idx;
                    idx = (ptr + k) % NREQ;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                check("grant", req_ready, 64'(1) << w);
                acc_id        = w;
                exp_ma        = op_a[w][head[w]];
                exp_mb        = op_b[w][head[w]];
                exp_start_cyc = cyc + 1;
                e.owner = w;
                e.err   = stall_mode;
                e.prod  = stall_mode ? 32'h0 : ref_mul(exp_ma, exp_mb);
                e.at    = stall_mode ? cyc + NB + 10 : cyc + LAT + 3;
                expq.push_back(e);
                next_idle = e.at + 1;
                ptr       = (w + 1) % NREQ;
            end else begin
                check("ready_busy", req_ready, 0);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (acc_id >= 0) head[acc_id]++;
        refresh();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_reset     = 1'b1;
        reset_cycles = 0;
        step();
        step();
        rst           = 1'b0;
        in_reset      = 1'b0;
        expq.delete();
        ptr           = 0;
        next_idle     = cyc + 1;
        exp_start_cyc = -1;
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += tail[i] - head[i];
        return n;
    endfunction

    task automatic wait_drain(input int maxc);
        int k = 0;
        while ((pending() > 0 || expq.size() > 0) && k < maxc) begin
            step();
            k++;
        end
        check("drain", pending() + expq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        refresh();
        do_reset();

        // Single request, small signed operands
        push(0, 16'h0007, 16'hFFFD);
        wait_drain(50);

        // Contention straight out of reset
        do_reset();
        for (int i = 0; i < NREQ; i++) push(i, 16'($urandom), 16'($urandom));
        wait_drain(100);

        // Fairness between two continuously valid requesters
        for (int n = 0; n < 3; n++) begin
            push(1, 16'($urandom), 16'($urandom));
            push(3, 16'($urandom), 16'($urandom));
        end
        wait_drain(100);

        // Operand extremes
        push(2, 16'h8000, 16'h8000);
        push(2, 16'h8000, 16'h7FFF);
        push(2, 16'h7FFF, 16'h7FFF);
        push(2, 16'h0000, 16'hFFFF);
        wait_drain(100);

        // Reset while the operation sits in WAIT_HI
        push(0, 16'h1234, 16'h00FF);
        k = 0;
        while (expq.size() == 0 && k < 20) begin
            step();
            k++;
        end
        check("midrst_accept", expq.size(), 1);
        step();
        step();
        do_reset();
        for (int n = 0; n < 8; n++) step();
        push(1, 16'hFFFF, 16'hFFFF);
        wait_drain(50);

`ifdef MULT_SCHED_TIMEOUT_EN
        // Multiplier never completes: expect an error response
        stall_mode = 1'b1;
        m_stall    = 1'b1;
        push(3, 16'h0101, 16'h0202);
        wait_drain(100);
        stall_mode = 1'b0;
        m_stall    = 1'b0;
        push(3, 16'h0101, 16'h0202);
        wait_drain(100);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int i;
                i = $urandom_range(0, NREQ - 1);
                if (tail[i] - head[i] < 3) push(i, 16'($urandom), 16'($urandom));
            end
            step();
        end
        wait_drain(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter NB, default 16: operand width in bits, matching the shared multiplier's nb.
REQ-002 Parameter NREQ, default 4, legal range 2..8: number of requesters.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high at a time.
REQ-007 req_a  input  NREQ*NB  signed multiplicands; slice i = [i*NB +: NB].
REQ-008 req_b  input  NREQ*NB  signed multipliers; same slicing as req_a.
REQ-009 rsp_valid  output  NREQ  one-hot, one-cycle response pulse to the owning requester.
REQ-010 rsp_product  output  2*NB  signed product; valid only while rsp_valid is nonzero.
REQ-011 rsp_err  output  1  timeout flag; qualified by rsp_valid.
REQ-012 mul_start  output  1  start pulse to the multiplier.
REQ-013 mul_a, mul_b  output  NB each  registered operands to the multiplier.
REQ-014 mul_product  input  2*NB  multiplier result.
REQ-015 mul_ready  input  1  multiplier done flag.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_LO, WAIT_HI and RESP.
REQ-017 In IDLE, req_ready SHALL be high only for the round-robin winner among the asserted req_valid bits; in all other states req_ready SHALL be 0.
REQ-018 Acceptance (req_valid[i] & req_ready[i]) SHALL latch req_a[i], req_b[i] and owner id i, then move IDLE->ISSUE.
REQ-019 In ISSUE, mul_start SHALL be 1 for exactly one cycle with mul_a/mul_b held stable; next state is WAIT_LO.
REQ-020 In WAIT_LO, the FSM SHALL move to WAIT_HI when mul_ready=0; in WAIT_HI, it SHALL move to RESP when mul_ready=1. This makes a stale ready level from a previous operation harmless.
REQ-021 On the WAIT_HI->RESP edge, mul_product SHALL be registered into rsp_product.
REQ-022 In RESP, rsp_valid[owner] SHALL be 1 for one cycle with rsp_err=0; next state is IDLE.
REQ-023 Round-robin rule: the priority pointer resets to 0; after granting requester i, requester (i+1) mod NREQ gets the highest priority.
REQ-024 Throughput SHALL be one operation per (multiplier latency + 4) cycles; acceptance-to-rsp_valid latency SHALL be multiplier latency + 3 cycles.
REQ-025 Requests that are not granted SHALL be held by their requester and never dropped; rsp_valid has no backpressure.
REQ-026 A req_valid arriving while the FSM is busy SHALL wait and be arbitrated on the next IDLE cycle.
REQ-027 rsp_product SHALL equal the exact signed 2*NB-bit product, with no truncation.

Reset
REQ-028 rst SHALL force IDLE, pointer=0, and req_ready=0, rsp_valid=0, rsp_product=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0.
REQ-029 Reset mid-operation SHALL abandon the in-flight result with no response issued; the multiplier itself is not reset, and the next mul_start restarts it.

Configuration
REQ-030 With MULT_SCHED_TIMEOUT_EN defined, a cycle counter SHALL run through WAIT_LO and WAIT_HI.
REQ-031 If the counter reaches NB+8 cycles, the FSM SHALL go to RESP with rsp_err=1 and rsp_product=0.
REQ-032 Without MULT_SCHED_TIMEOUT_EN, no counter SHALL exist, rsp_err SHALL be tied to 0, and the wait states SHALL be unbounded.

Structure
REQ-033 Package mult_sched_pkg SHALL hold the state enum typedef, the default NB/NREQ constants and the TIMEOUT_SLACK=8 constant.
REQ-034 Sub-module rr_arbiter SHALL contain the NREQ-wide round-robin grant logic (pointer register plus one-hot grant); the FSM and datapath stay in mult_sched.

Verification
REQ-035 Single request: req 0 with a=16'h0007, b=16'hFFFD -> one mul_start pulse, then rsp_valid=4'b0001 with rsp_product=32'hFFFFFFEB (-21), rsp_err=0.
REQ-036 Contention: all four requesters valid at once after reset -> grant order 0,1,2,3, each response going to its owner with the correct product.
REQ-037 Fairness: requesters 1 and 3 held valid continuously for 6 operations -> grants alternate 1,3,1,3,1,3.
REQ-038 Extremes: a=16'h8000, b=16'h8000 -> rsp_product=32'h40000000; a=16'h8000, b=16'h7FFF -> 32'hC0008000.
REQ-039 Mid-operation reset: rst pulsed in WAIT_HI -> no rsp_valid for that request, all outputs at reset values, and the next request completes correctly.
REQ-040 Timeout (MULT_SCHED_TIMEOUT_EN defined): mul_ready held low -> rsp_valid to the owner with rsp_err=1 and rsp_product=0, exactly NB+8 cycles after WAIT_LO entry.
